// File: rtl/systolic_pkg.sv
// Shared types and the accumulator saturate/wrap helper for the systolic matmul engine.
package systolic_pkg;

  // sat_trunc is built for this accumulator width; the engine's BITS_C defaults to it.
  localparam int SAT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN
  } state_e;

  typedef struct packed {
    logic signed [SAT_W-1:0] val;
    logic                    ovf;
  } sat_t;

  function automatic sat_t sat_trunc(input logic signed [SAT_W:0] sum, input logic sat_en);
    sat_t res;
    res.ovf = sum[SAT_W] ^ sum[SAT_W-1];
    res.val = sum[SAT_W-1:0];
    if (res.ovf && sat_en) begin
      res.val = sum[SAT_W] ? {1'b1, {(SAT_W-1){1'b0}}} : {1'b0, {(SAT_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC cell: A moves right, B moves down, the product accumulates in place.
module sa_pe
  import systolic_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = SAT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      adv,
  input  logic                      sat_en,
  input  logic signed [BITS_AB-1:0] a_in,
  input  logic signed [BITS_AB-1:0] b_in,
  output logic signed [BITS_AB-1:0] a_out,
  output logic signed [BITS_AB-1:0] b_out,
  output logic signed [BITS_C-1:0]  acc,
  output logic                      ovf_evt
);

  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C:0]      sum;
  sat_t                        res;

  // One guard bit above the accumulator exposes every overflow to sat_trunc.
  always_comb begin
    prod    = a_in * b_in;
    sum     = $signed({{(BITS_C+1-2*BITS_AB){prod[2*BITS_AB-1]}}, prod})
            + $signed({acc[BITS_C-1], acc});
    res     = sat_trunc(sum, sat_en);
    ovf_evt = adv & res.ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (adv) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= res.val;
    end
  end

endmodule

// File: rtl/systolic_engine.sv
// Self-sequencing ROWSxCOLS output-stationary matmul engine: load K skewed beats, flush, drain C by rows.
module systolic_engine
  import systolic_pkg::*;
#(
  parameter  int BITS_AB = 8,
  parameter  int BITS_C  = SAT_W,
  parameter  int ROWS    = 8,
  parameter  int COLS    = 8,
  parameter  int KMAX    = 255,
  localparam int KW      = $clog2(KMAX + 1),
  localparam int IW      = $clog2(ROWS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [KW-1:0]                  k_len,
  input  logic                           sat_en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROWS-1:0][BITS_AB-1:0]   a_vec,
  input  logic [COLS-1:0][BITS_AB-1:0]   b_vec,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COLS-1:0][BITS_C-1:0]    c_row,
  output logic [IW-1:0]                  c_idx,
  output logic                           busy,
  output logic                           ovf,
  output logic                           done
);

  localparam int FW = $clog2(ROWS + COLS);

  state_e          state, state_nxt;
  logic [KW-1:0]   k_len_q, k_cnt;
  logic [FW-1:0]   f_cnt;
  logic            sat_q;
  logic            beat, adv, clr;
  logic            last_beat, flush_end, drain_last;

  logic signed [BITS_AB-1:0] a_h [ROWS][COLS+1];
  logic signed [BITS_AB-1:0] b_v [ROWS+1][COLS];
  logic signed [BITS_C-1:0]  acc [ROWS][COLS];
  logic [ROWS*COLS-1:0]      ovf_evt;

  assign beat       = (state == LOAD) & in_valid;
  assign adv        = beat | (state == FLUSH);
  assign clr        = (state == IDLE) & start;
  assign last_beat  = beat && (k_cnt == k_len_q - 1'b1);
  assign flush_end  = (state == FLUSH) && (f_cnt == FW'(ROWS + COLS - 2));
  assign drain_last = (state == DRAIN) && out_ready && (c_idx == IW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (k_len == '0) ? DRAIN : LOAD;
      LOAD:  if (last_beat) state_nxt = FLUSH;
      FLUSH: if (flush_end) state_nxt = DRAIN;
      DRAIN: if (drain_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
  end

  // Run bookkeeping; start wipes every trace of the previous run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_q <= '0;
      sat_q   <= 1'b0;
      k_cnt   <= '0;
      f_cnt   <= '0;
      c_idx   <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= drain_last;
      if (clr) begin
        k_len_q <= k_len;
        sat_q   <= sat_en;
        k_cnt   <= '0;
        f_cnt   <= '0;
        c_idx   <= '0;
        ovf     <= 1'b0;
      end else begin
        if (beat) k_cnt <= k_cnt + 1'b1;
        if (state == FLUSH) f_cnt <= f_cnt + 1'b1;
        if ((state == DRAIN) && out_ready) c_idx <= drain_last ? '0 : c_idx + 1'b1;
        ovf <= ovf | (|ovf_evt);
      end
    end
  end

  // Row r of A enters r steps late so that A and B meet on the anti-diagonal wavefront.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_h[r][0] = beat ? a_vec[r] : '0;
    end else begin : g_delay
      logic signed [BITS_AB-1:0] d [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) d[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < r; i++) d[i] <= '0;
        end else if (adv) begin
          d[0] <= beat ? a_vec[r] : '0;
          for (int i = 1; i < r; i++) d[i] <= d[i-1];
        end
      end
      assign a_h[r][0] = d[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign b_v[0][c] = beat ? b_vec[c] : '0;
    end else begin : g_delay
      logic signed [BITS_AB-1:0] d [c];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) d[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < c; i++) d[i] <= '0;
        end else if (adv) begin
          d[0] <= beat ? b_vec[c] : '0;
          for (int i = 1; i < c; i++) d[i] <= d[i-1];
        end
      end
      assign b_v[0][c] = d[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(
        .BITS_AB(BITS_AB),
        .BITS_C (BITS_C)
      ) u_pe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .adv    (adv),
        .sat_en (sat_q),
        .a_in   (a_h[r][c]),
        .b_in   (b_v[r][c]),
        .a_out  (a_h[r][c+1]),
        .b_out  (b_v[r+1][c]),
        .acc    (acc[r][c]),
        .ovf_evt(ovf_evt[r*COLS+c])
      );
    end
  end

  always_comb begin
    c_row = '0;
    if (out_valid) begin
      for (int c = 0; c < COLS; c++) c_row[c] = acc[c_idx][c];
    end
  end

endmodule

// File: tb/tb_systolic_engine.sv
// Directed bench for systolic_engine (4x4): a matrix-level model predicts every drained row.
module tb_systolic_engine;
  import systolic_pkg::*;

  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int KMAX    = 255;
  localparam int KW      = $clog2(KMAX + 1);
  localparam int IW      = $clog2(ROWS);
  localparam int MAXK    = 8;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic                         sat_en = 1'b0;
  logic                         in_valid = 1'b0;
  logic                         out_ready = 1'b0;
  logic [KW-1:0]                k_len = '0;
  logic [ROWS-1:0][BITS_AB-1:0] a_vec = '0;
  logic [COLS-1:0][BITS_AB-1:0] b_vec = '0;
  logic                         in_ready, out_valid, busy, ovf, done;
  logic [COLS-1:0][BITS_C-1:0]  c_row;
  logic [IW-1:0]                c_idx;

  int vectors     = 0;
  int miscompares = 0;
  int a_m [ROWS][MAXK];
  int b_m [MAXK][COLS];
  int exp_c [ROWS][COLS];
  bit exp_ovf;
  int exp_idx    = 0;
  bit exp_done   = 1'b0;
  int done_count = 0;

  always #5 clk = ~clk;

  systolic_engine #(
    .BITS_AB(BITS_AB),
    .BITS_C (BITS_C),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .KMAX   (KMAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .sat_en   (sat_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c_row    (c_row),
    .c_idx    (c_idx),
    .busy     (busy),
    .ovf      (ovf),
    .done     (done)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // C = A*B accumulated in k order, each partial sum clamped or wrapped to 16 bits.
  function automatic void computeModel(input int k, input bit sat);
    int s;
    exp_ovf = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          s = s + a_m[r][kk] * b_m[kk][c];
          if (s > 32767) begin
            exp_ovf = 1'b1;
            s = sat ? 32767 : s - 65536;
          end else if (s < -32768) begin
            exp_ovf = 1'b1;
            s = sat ? -32768 : s + 65536;
          end
        end
        exp_c[r][c] = s;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx  = 0;
      exp_done = 1'b0;
    end else begin
      checkOutput("done", int'(done), int'(exp_done));
      if (done) done_count++;
      exp_done = 1'b0;
      if (out_valid) begin
        checkOutput("c_idx", int'(c_idx), exp_idx);
        for (int c = 0; c < COLS; c++)
          checkOutput($sformatf("c_row[%0d][%0d]", exp_idx, c), $signed(c_row[c]), exp_c[exp_idx][c]);
        if (out_ready) begin
          exp_done = (exp_idx == ROWS - 1);
          exp_idx  = (exp_idx + 1) % ROWS;
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " in_ready"}, int'(in_ready), 0);
    checkOutput({tag, " out_valid"}, int'(out_valid), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " ovf"}, int'(ovf), 0);
    checkOutput({tag, " c_idx"}, int'(c_idx), 0);
    for (int c = 0; c < COLS; c++) checkOutput({tag, " c_row"}, int'(c_row[c]), 0);
  endtask

  task automatic applyStimulus(input string tag, input int k, input bit sat,
                               input bit [15:0] vpat, input int vlen,
                               input int hold_row, input int hold_cycles, input bit abort_in_flush);
    int sent, cyc, lat, shakes, held;
    computeModel(k, sat);
    done_count = 0;
    @(posedge clk); #1;
    start  = 1'b1;
    k_len  = KW'(k);
    sat_en = sat;
    @(posedge clk); #1;
    start  = 1'b0;
    k_len  = KW'($urandom_range(1, 9));
    sat_en = ~sat;
    sent = 0;
    cyc  = 0;
    while (sent < k && cyc < 200) begin
      in_valid = vpat[cyc % vlen];
      for (int r = 0; r < ROWS; r++)
        a_vec[r] = in_valid ? BITS_AB'(a_m[r][sent]) : BITS_AB'($urandom);
      for (int c = 0; c < COLS; c++)
        b_vec[c] = in_valid ? BITS_AB'(b_m[sent][c]) : BITS_AB'($urandom);
      @(negedge clk);
      checkOutput({tag, " in_ready load"}, int'(in_ready), 1);
      @(posedge clk); #1;
      if (in_valid) sent++;
      cyc++;
    end
    if (sent < k) checkOutput({tag, " load beats"}, sent, k);
    in_valid = 1'b1;
    a_vec = {ROWS{8'h7f}};
    b_vec = {COLS{8'h7f}};
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 64) begin
      checkOutput({tag, " in_ready flush"}, int'(in_ready), 0);
      if (abort_in_flush && lat == 4) begin
        checkOutput({tag, " ovf before reset"}, int'(ovf), 1);
        rst_n = 1'b0;
        #2;
        checkResetOutputs({tag, " mid-run reset"});
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      start = (lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, lat, (k == 0) ? 1 : ROWS + COLS);
    shakes = 0;
    held   = 0;
    cyc    = 0;
    while (shakes < ROWS && cyc < 64) begin
      @(posedge clk); #1;
      out_ready = !(shakes == hold_row && held < hold_cycles);
      if (!out_ready) held++;
      @(negedge clk);
      checkOutput({tag, " in_ready drain"}, int'(in_ready), 0);
      if (out_valid && out_ready) shakes++;
      cyc++;
    end
    checkOutput({tag, " rows drained"}, shakes, ROWS);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    checkOutput({tag, " busy after drain"}, int'(busy), 0);
    checkOutput({tag, " ovf"}, int'(ovf), int'(exp_ovf));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " done pulses"}, done_count, 1);
  endtask

  task automatic loadIdentity();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < MAXK; k++) a_m[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < MAXK; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = k * COLS + c + 1;
  endtask

  task automatic loadConst(input int v);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < MAXK; k++) a_m[r][k] = v;
    for (int k = 0; k < MAXK; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = v;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    loadIdentity();
    applyStimulus("identity", 4, 1'b0, 16'h0001, 1, -1, 0, 1'b0);
    checkOutput("model identity C[1][2]", exp_c[1][2], 7);
    checkOutput("identity ovf literal", int'(ovf), 0);

    loadConst(127);
    applyStimulus("saturate", 4, 1'b1, 16'h0001, 1, -1, 0, 1'b0);
    checkOutput("model saturate C[2][1]", exp_c[2][1], 32767);
    checkOutput("saturate ovf literal", int'(ovf), 1);

    applyStimulus("wrap hold", 4, 1'b0, 16'h0001, 1, 2, 5, 1'b0);
    checkOutput("model wrap C[3][3]", exp_c[3][3], -1020);
    checkOutput("wrap ovf literal", int'(ovf), 1);

    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < MAXK; k++) a_m[r][k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < MAXK; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = int'($urandom_range(0, 255)) - 128;
    applyStimulus("random stall", 3, 1'b0, 16'b101001, 6, -1, 0, 1'b0);

    applyStimulus("k zero", 0, 1'b0, 16'h0001, 1, 1, 2, 1'b0);
    checkOutput("model k zero C[3][0]", exp_c[3][0], 0);

    loadConst(127);
    applyStimulus("abort", 4, 1'b0, 16'h0001, 1, -1, 0, 1'b1);

    loadIdentity();
    applyStimulus("after reset", 4, 1'b0, 16'h0001, 1, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
